// File: rtl/block_dispatcher.sv
`timescale 1ns/1ps
// block_dispatcher: splits a kernel launch into fixed-size thread blocks and
// hands them to free compute cores, reporting done once every block completes.
module block_dispatcher #(
    parameter int NUM_CORES = 2,
    parameter int THREADS_PER_BLOCK = 4,
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               thread_count,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [8*NUM_CORES-1:0]   core_block_id,
    output logic [TCW*NUM_CORES-1:0] core_thread_count,
    input  logic [NUM_CORES-1:0]     core_done,
    output logic                     done
);
    localparam int LOG2 = $clog2(THREADS_PER_BLOCK);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {FREE, BUSY, DRAIN} slot_t;

    state_t                   state_q, state_d;
    slot_t                    slot_q [NUM_CORES];
    slot_t                    slot_d [NUM_CORES];
    logic [7:0]               tc_q, tc_d, next_q, next_d, bdone_q, bdone_d;
    logic                     done_q, done_d, found;
    logic [NUM_CORES-1:0]     start_q, start_d;
    logic [8*NUM_CORES-1:0]   bid_q, bid_d;
    logic [TCW*NUM_CORES-1:0] cnt_q, cnt_d;
    logic [8:0]               sum9;
    logic [7:0]               total;
    logic [TCW-1:0]           rem, last_cnt;
    logic                     disp_en;

    assign sum9     = {1'b0, tc_q} + 9'(THREADS_PER_BLOCK - 1);
    assign total    = 8'(sum9 >> LOG2);
    assign rem      = TCW'(tc_q & 8'(THREADS_PER_BLOCK - 1));
    // only the final block of a non-multiple kernel is partial
    assign last_cnt = (next_q == total - 8'd1 && rem != '0) ? rem : TCW'(THREADS_PER_BLOCK);
    assign disp_en  = state_q == RUN && bdone_q != total && next_q < total;

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        next_d  = next_q;
        bdone_d = bdone_q;
        done_d  = done_q;
        start_d = start_q;
        bid_d   = bid_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        found   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (slot_q[i] == BUSY && core_done[i]) begin
                slot_d[i]  = DRAIN;
                start_d[i] = 1'b0;
                bdone_d    = bdone_d + 8'd1;
            end else if (slot_q[i] == DRAIN) begin
                slot_d[i] = FREE;
            end else if (slot_q[i] == FREE && disp_en && !found) begin
                found                 = 1'b1;
                slot_d[i]             = BUSY;
                start_d[i]            = 1'b1;
                bid_d[i*8 +: 8]       = next_q;
                cnt_d[i*TCW +: TCW]   = last_cnt;
            end
        end
        next_d = next_q + {7'd0, found};
        if (state_q == RUN) begin
            state_d = bdone_q == total ? DONE : RUN;
            done_d  = bdone_q == total;
        end else if (start) begin
            state_d = RUN;
            tc_d    = thread_count;
            next_d  = 8'd0;
            bdone_d = 8'd0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tc_q    <= 8'd0;
            next_q  <= 8'd0;
            bdone_q <= 8'd0;
            done_q  <= 1'b0;
            start_q <= '0;
            bid_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= FREE;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            next_q  <= next_d;
            bdone_q <= bdone_d;
            done_q  <= done_d;
            start_q <= start_d;
            bid_q   <= bid_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

    assign core_start        = start_q;
    assign core_block_id     = bid_q;
    assign core_thread_count = cnt_q;
    assign done              = done_q;
endmodule

// File: tb/tb_block_dispatcher.sv
`timescale 1ns/1ps
// tb_block_dispatcher: random kernels against a block-level reference model of
// the dispatcher, with core behaviour emulated by the bench.
module tb_block_dispatcher;
    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TCW = $clog2(TPB) + 1;

    logic              clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [7:0]        thread_count = 8'd0;
    logic [NC-1:0]     core_start, core_done = '0;
    logic [8*NC-1:0]   core_block_id;
    logic [TCW*NC-1:0] core_thread_count;
    logic              done;
    int                compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .core_start(core_start), .core_block_id(core_block_id),
        .core_thread_count(core_thread_count), .core_done(core_done), .done(done)
    );

    // reference model: 0 = core idle, 1 = core working, 2 = core dropping done
    int             slot [NC];
    int             tmr [NC];
    logic [7:0]     eid [NC];
    logic [TCW-1:0] ecnt [NC];
    logic           es [NC];
    logic           edone;
    bit             run;
    int             nb, bd, total, tcl;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NC-1:0] s;
        logic [8*NC-1:0] b;
        logic [TCW*NC-1:0] t;
        for (int c = 0; c < NC; c++) begin
            s[c] = es[c];
            b[c*8 +: 8] = eid[c];
            t[c*TCW +: TCW] = ecnt[c];
        end
        check({tag, ".core_start"}, 64'(core_start), 64'(s));
        check({tag, ".block_id"}, 64'(core_block_id), 64'(b));
        check({tag, ".thread_count"}, 64'(core_thread_count), 64'(t));
        check({tag, ".done"}, 64'(done), 64'(edone));
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            slot[c] = 0; tmr[c] = 0; eid[c] = 8'd0; ecnt[c] = '0; es[c] = 1'b0;
        end
        edone = 1'b0; run = 0; nb = 0; bd = 0; total = 0; tcl = 0;
    endtask

    // one clock: drive core behaviour and optional launch, predict, then compare
    task automatic step(input string tag, input bit launch, input int tc,
                        input bit sync, input int maxlat);
        int tgt, nbusy, rem;
        bit fin;
        logic [NC-1:0] cd;
        nbusy = 0;
        for (int c = 0; c < NC; c++) if (slot[c] == 1) nbusy++;
        for (int c = 0; c < NC; c++)
            cd[c] = slot[c] == 1 ? (sync ? (nbusy == NC || nb == total) : tmr[c] == 0)
                                 : $urandom_range(0, 3) == 0;
        core_done = cd;
        if (launch) begin start = 1'b1; thread_count = 8'(tc); end
        tgt = -1;
        if (run && bd != total && nb < total)
            for (int c = 0; c < NC; c++) if (tgt < 0 && slot[c] == 0) tgt = c;
        fin = run && bd == total;
        for (int c = 0; c < NC; c++) begin
            if (slot[c] == 2) slot[c] = 0;
            else if (slot[c] == 1 && cd[c]) begin slot[c] = 2; es[c] = 1'b0; bd++; end
            else if (slot[c] == 1 && tmr[c] > 0) tmr[c]--;
        end
        if (tgt >= 0) begin
            rem = tcl - nb * TPB;
            slot[tgt] = 1; es[tgt] = 1'b1; eid[tgt] = 8'(nb);
            ecnt[tgt] = TCW'(rem >= TPB ? TPB : rem);
            tmr[tgt] = $urandom_range(0, maxlat);
            nb++;
        end
        if (fin) begin run = 0; edone = 1'b1; end
        if (launch && !run && !fin) begin
            tcl = tc; total = (tc + TPB - 1) / TPB; nb = 0; bd = 0; edone = 1'b0; run = 1;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        core_done = '0;
        check_outputs(tag);
    endtask

    task automatic run_kernel(input string tag, input int tc, input bit sync,
                              input int maxlat, input bit poke, input int abort_at);
        int cyc;
        cyc = 0;
        step({tag, ".launch"}, 1'b1, tc, sync, maxlat);
        while (run && cyc < 2000 && !(abort_at > 0 && cyc >= abort_at)) begin
            step(tag, poke && cyc == 2, 200, sync, maxlat);
            cyc++;
        end
        if (abort_at == 0) begin
            check({tag, ".finished"}, 64'(run), 64'd0);
            step({tag, ".idle"}, 1'b0, 0, sync, maxlat);
            step({tag, ".idle"}, 1'b0, 0, sync, maxlat);
        end
    endtask

    initial begin
        #5ms;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        step("idle", 1'b0, 0, 1'b0, 0);
        step("idle", 1'b0, 0, 1'b0, 0);
        run_kernel("tc10", 10, 1'b0, 3, 1'b0, 0);
        run_kernel("tc8", 8, 1'b0, 2, 1'b0, 0);
        run_kernel("tc0", 0, 1'b0, 0, 1'b0, 0);
        run_kernel("tc8_sync", 8, 1'b1, 0, 1'b0, 0);
        run_kernel("tc10_sync", 10, 1'b1, 0, 1'b0, 0);
        run_kernel("tc9_poke", 9, 1'b0, 3, 1'b1, 0);
        run_kernel("tc1", 1, 1'b0, 1, 1'b0, 0);
        run_kernel("tc255", 255, 1'b0, 2, 1'b0, 0);
        for (int k = 0; k < 15; k++)
            run_kernel("rand", $urandom_range(0, 40), 1'(k % 3 == 0), $urandom_range(0, 4),
                       1'($urandom_range(0, 1)), 0);
        run_kernel("abort", 40, 1'b0, 3, 1'b0, 6);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        reset = 1'b1;
        run_kernel("after_reset", 4, 1'b0, 2, 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/block_dispatcher.md
# block_dispatcher

Kernel-level work distributor that sits directly upstream of the compute cores. On a kernel launch it splits the total thread count into blocks of THREADS_PER_BLOCK threads and hands each block to a free core via that core's start, block_id and thread_count inputs. It watches each core's done flag to reclaim the core, and it raises a kernel-level done once every block has completed.

## Interface
- NUM_CORES, default 2: number of compute cores driven. Must be 1 to 8.
- THREADS_PER_BLOCK, default 4: threads per block. Must be a power of two, 1 to 128.
- clk  in  1: clock. All state changes on the rising edge.
- reset  in  1: asynchronous, active-low reset. Low clears all state immediately.
- start  in  1: kernel launch request. Sampled in IDLE and DONE only.
- thread_count  in  8: total kernel threads (0 to 255). Latched on an accepted start.
- core_start  out  NUM_CORES: per-core start. Held high while that core owns a block.
- core_block_id  out  8 x NUM_CORES: block index assigned to each core.
- core_thread_count  out  ($clog2(THREADS_PER_BLOCK)+1) x NUM_CORES: active threads in the assigned block.
- core_done  in  NUM_CORES: per-core completion flag.
- done  out  1: kernel complete. Held high in DONE.

## Operation
- Reset values:
  - state = IDLE.
  - core_start = 0; every core_block_id and core_thread_count = 0.
  - done = 0; all internal counters and slot states = 0 / FREE.
- Launch:
  - start high at an edge in IDLE or DONE latches thread_count into tc_q.
  - total_blocks = (tc_q + THREADS_PER_BLOCK - 1) >> log2(THREADS_PER_BLOCK). Use a 9-bit intermediate so there is no overflow at 255.
  - next_block and blocks_done are cleared; done drops; state goes to RUN.
- Global state machine:
  - IDLE: go to RUN on start.
  - RUN: go to DONE when blocks_done == total_blocks.
  - DONE: stay; go to RUN on start.
  - start is ignored while in RUN.
- Per-core slot states: FREE, BUSY, DRAIN.
  - FREE to BUSY on dispatch.
  - BUSY to DRAIN when core_done is sampled high.
  - DRAIN to FREE after exactly one cycle, so the core can drop done.
- Dispatch, in RUN only:
  - At most one dispatch per cycle.
  - Eligible when next_block < total_blocks and at least one slot is FREE.
  - Target is the lowest-index FREE core.
  - On dispatch: core_block_id = next_block; core_start = 1; next_block increments.
  - core_thread_count = THREADS_PER_BLOCK, except for the last block when tc_q is not a multiple. The last block gets tc_q mod THREADS_PER_BLOCK.
- Completion:
  - core_done is sampled only for BUSY slots.
  - On that edge core_start drops to 0. core_block_id and core_thread_count hold their values.
  - blocks_done increments by the number of slots completing that edge. Simultaneous completions are all counted in the same edge.
  - core_done on FREE or DRAIN slots is ignored.
- Zero threads: total_blocks = 0. No core is started; DONE is entered on the first RUN edge.
- Reset asserted mid-kernel: all outputs return to reset values asynchronously. In-flight blocks are abandoned.

## Timing
- start at edge N: RUN from N. The first dispatch (core 0) is visible after edge N+1. Further dispatches follow on one core per edge (N+2, ...) while free cores remain.
- core_done high at edge M (slot BUSY):
  - core_start low after M.
  - Slot in DRAIN during cycle M to M+1.
  - Slot may be re-dispatched at edge M+2.
- done rises at the edge following the edge where blocks_done reaches total_blocks. It stays high until the next accepted start or reset.
- Zero-thread launch: done high after edge N+1.
- Counters are 8-bit. next_block never exceeds total_blocks, so there is no wrap-around.

## Test plan
- 10 threads, TPB=4, 2 cores:
  - Core 0 gets block 0 (count 4) after edge N+1; core 1 gets block 1 (count 4) after N+2.
  - core_done[0] at M: core 0 gets block 2 (count 2) after M+2.
  - done rises after all three blocks complete.
- 8 threads: blocks 0 and 1, both with count 4. No partial block. done after both core_done.
- thread_count = 0: core_start stays 0; done high after edge N+1.
- Both core_done high on the same edge: blocks_done += 2 and both core_start drop on that edge. A launch with exactly two blocks reaches DONE on the next edge.
- start pulsed in RUN with thread_count = 200: ignored. Block count and dispatch order are unchanged.
- Reset low mid-kernel (1 ns pulse, asynchronous): core_start = 0 and done = 0 immediately. A new start of 4 threads then dispatches block 0, count 4, to core 0.
